// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, divide-by-zero quotient.
// Optional build macro MULDIV_FLUSH_EN is consumed by muldiv_unit, not here.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV0_QUOT = {64{1'b1}};

    function automatic logic is_signed_op(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e o);
        return (o == MD_DIVU) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational shift-add (multiply) or restoring shift-subtract (divide) iteration.
// The shared WIDTH+1-bit adder's carry-out selects keep (no borrow) vs. restore on divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e             mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               cur_bit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH+1:0] add_res;

    // Divide subtracts the divisor from the shifted partial remainder; multiply conditionally adds.
    always_comb begin
        if (is_div_op(mode)) begin
            add_a   = acc[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, operand};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
            add_b   = cur_bit ? {1'b0, operand} : {(WIDTH+1){1'b0}};
            add_cin = 1'b0;
        end
        add_res = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
        if (is_div_op(mode)) begin
            if (add_res[WIDTH+1]) begin
                acc_next = {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_res[WIDTH:0], acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes when not busy.
// Defining MULDIV_FLUSH_EN adds a flush input that abandons an in-flight operation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITERS + 1);

    md_state_e          state_r;
    md_op_e             op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div0_r;
    logic               flush_s;
    logic               wr_ok_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

`ifdef MULDIV_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // MTHI/MTLO land only in IDLE or DONE; FIX is reserved for the result write.
    assign wr_ok_s = (state_r == S_IDLE) || (state_r == S_DONE);

    // Operand magnitudes and sign flags for the signed ops.
    always_comb begin
        a_neg_s = is_signed_op(op_r) && a_r[WIDTH-1];
        b_neg_s = is_signed_op(op_r) && b_r[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - a_r) : a_r;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - b_r) : b_r;
    end

    // Sign correction of the raw magnitude result; divide by zero forces an all-ones quotient.
    always_comb begin
        prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        if (is_div_op(op_r)) begin
            fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            if (div0_r) begin
                fix_lo_s = DIV0_QUOT[WIDTH-1:0];
            end else if (neg_q_r) begin
                fix_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
            end else begin
                fix_lo_s = acc_r[WIDTH-1:0];
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (op_r),
        .acc      (acc_r),
        .operand  (opnd_r),
        .cur_bit  (acc_r[0]),
        .acc_next (acc_next_s)
    );

    // Sequencer FSM with registered busy/done and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            op_r    <= MD_MULTU;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            if (wr_ok_s && hi_we) begin
                hi <= wdata;
            end
            if (wr_ok_s && lo_we) begin
                lo <= wdata;
            end
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start && !flush_s) begin
                        op_r    <= md_op_e'(op);
                        a_r     <= rs_val;
                        b_r     <= rt_val;
                        state_r <= S_PREP;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (flush_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                        opnd_r  <= b_mag_s;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        div0_r  <= is_div_op(op_r) && (b_r == {WIDTH{1'b0}});
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (flush_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(ITERS - 1)) begin
                            state_r <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush_s) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        hi      <= fix_hi_s;
                        lo      <= fix_lo_s;
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed vectors.
// Build with +define+MULDIV_FLUSH_EN to also exercise the flush port.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en;

    // Reference model state: cycles left in the operation, pending result, visible HI/LO.
    int          m_rem;
    logic [63:0] m_pend;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_done;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef MULDIV_FLUSH_EN
        .flush  (flush),
`endif
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] p;
        case (o)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end
            2'b10: p = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    q  = ia / ib;
                    r  = ia % ib;
                    p  = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_done <= 1'b0;
            m_pend <= 64'h0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start && !flush) begin
                    m_rem  <= LAT;
                    m_pend <= ref_result(op, rs_val, rt_val);
                end
            end else if (flush) begin
                m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("cyc busy", 64'(busy), 64'(m_rem != 0));
            chk("cyc done", 64'(done), 64'(m_done));
            chk("cyc hi", 64'(hi), 64'(m_hi));
            chk("cyc lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit b2b, input bit disturb, input bit mt_start);
        int lat;
        int bc;
        if (!b2b) @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        hi_we = mt_start; wdata = 32'h0000_5555;
        lat = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            lat++;
            start  = 1'b0;
            op     = 2'($urandom);
            rs_val = $urandom;
            rt_val = $urandom;
            if (mt_start && lat == 1) chk({name, " mthi with start"}, 64'(hi), 64'h5555);
            if (disturb && lat == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1;
            end else begin
                hi_we = 1'b0; lo_we = 1'b0;
            end
            if (busy) bc++;
        end while (!done && lat < 200);
        chk({name, " latency"}, 64'(lat - 1), 64'(LAT));
        chk({name, " busy cycles"}, 64'(bc), 64'(LAT));
        chk({name, " hi"}, 64'(hi), 64'(exp[63:32]));
        chk({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    endtask

    task automatic pin(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        chk(name, ref_result(o, a, b), exp);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00;
        rs_val = 32'h0; rt_val = 32'h0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0; chk_en = 1'b0;

        pin("ref multu", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        pin("ref mult",  2'b01, 32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB);
        pin("ref div",   2'b11, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD);
        pin("ref divu",  2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
        pin("ref div0",  2'b11, 32'h8000_0005, 32'h0,         64'h8000_0005_FFFF_FFFF);
        pin("ref ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        chk("reset hi", 64'(hi), 64'h0);
        chk("reset lo", 64'(lo), 64'h0);

        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_4321;
        chk("mthi idle", 64'(hi), 64'h1234);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo idle", 64'(lo), 64'h4321);

        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0);
        run_op("mult neg",  2'b01, 32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 1'b1);
        run_op("div neg",   2'b11, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op("divu busy", 2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0, 1'b1, 1'b0);
        run_op("divu by0",  2'b10, 32'h8000_0005, 32'h0,         64'h8000_0005_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("div by0",   2'b11, 32'h8000_0005, 32'h0,         64'h8000_0005_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("div ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 1'b0);
        run_op("mult min",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("div negd",  2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset landing at iteration 10 of a multiply.
        @(negedge clk);
        op = 2'b00; rs_val = 32'h0001_0003; rt_val = 32'h0000_0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'h0);
        chk("midrst hi", 64'(hi), 64'h0);
        chk("midrst lo", 64'(lo), 64'h0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst no done", 64'(dcnt), 64'h0);

`ifdef MULDIV_FLUSH_EN
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'h0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("flush no done", 64'(dcnt), 64'h0);
        chk("flush hi kept", 64'(hi), 64'hAAAA_0001);
        chk("flush lo kept", 64'(lo), 64'hAAAA_0001);
        op = 2'b00; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush blocks start", 64'(busy), 64'h0);
        repeat (2) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
